// File: rtl/key_storage_pkg.sv
// -----------------------------------------------------------------------------
// key_storage_pkg
// Shared definitions for the round-key ring store:
//   - read-out direction encodings (forward / reverse)
//   - AES round-key counts for 128/192/256-bit keys
//   - helper that derives the pointer index width from the store depth
// -----------------------------------------------------------------------------
package key_storage_pkg;

  // Read-out direction: forward replays keys for encryption, reverse for decryption.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Number of round keys produced by the AES key schedule.
  localparam int AES128_NUM_KEYS = 32'sd11;
  localparam int AES192_NUM_KEYS = 32'sd13;
  localparam int AES256_NUM_KEYS = 32'sd15;

  // Index width for a store of the given depth; never narrower than one bit.
  function automatic int calc_ptr_w(input int depth);
    if (depth <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage : key_storage_pkg

// File: rtl/key_ring_ptr.sv
// -----------------------------------------------------------------------------
// key_ring_ptr
// Circular read pointer for the round-key ring store.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      synchronous flush, pointer returns to 0
//   count      current occupancy of the store (before any same-cycle write)
//   dir        0 = forward, 1 = reverse
//   rd_en      step the pointer one entry in direction dir, wrapping at count
//   rewind     jump to the first entry of the traversal for dir
//   rd_ptr     registered pointer
// -----------------------------------------------------------------------------
module key_ring_ptr
  import key_storage_pkg::*;
#(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [PTR_W:0]   count,
  input  logic             dir,
  input  logic             rd_en,
  input  logic             rewind,
  output logic [PTR_W-1:0] rd_ptr
);

  localparam logic [PTR_W-1:0] PTR_ZERO = '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] last_idx_s;
  logic             empty_s;

  // Highest occupied index; only meaningful when the store is non-empty.
  assign last_idx_s = PTR_W'(count - {{PTR_W{1'b0}}, 1'b1});
  assign empty_s    = (count == '0);

  // Next pointer: clear beats rewind, rewind beats a read step.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = PTR_ZERO;
    end else if (rewind) begin
      // An empty store has no last entry, so both directions land on 0.
      if (empty_s) begin
        ptr_d = PTR_ZERO;
      end else if (dir == DIR_REV) begin
        ptr_d = last_idx_s;
      end else begin
        ptr_d = PTR_ZERO;
      end
    end else if (rd_en && !empty_s) begin
      if (dir == DIR_REV) begin
        ptr_d = (ptr_q == PTR_ZERO) ? last_idx_s : (ptr_q - PTR_ONE);
      end else begin
        ptr_d = (ptr_q == last_idx_s) ? PTR_ZERO : (ptr_q + PTR_ONE);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_ZERO;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign rd_ptr = ptr_q;

endmodule : key_ring_ptr

// File: rtl/key_ring_store.sv
// -----------------------------------------------------------------------------
// key_ring_store
// Round-key storage between key expansion and the round datapath. Keys are
// appended once, then replayed forward (encryption) or reverse (decryption)
// around a circular pointer as many times as needed.
// Ports:
//   clk, rst    clock and asynchronous active-high reset (clears memory too)
//   clear       synchronous flush of count, pointer and err; memory kept
//   wr_en, din  append din at index count; dropped with err when full
//   rd_en, dir  step the read pointer forward (dir=0) or reverse (dir=1)
//   rewind      move pointer to the start of the traversal for dir
//   dout        entry at the read pointer
//   dout_valid  store is non-empty
//   count       number of stored entries, 0..DEPTH
//   full/empty  occupancy flags
//   last        dout is the final entry of the current traversal
//   err         sticky: write while full or read while empty
// -----------------------------------------------------------------------------
module key_ring_store
  import key_storage_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = AES256_NUM_KEYS,
  parameter int PTR_W = calc_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             dir,
  input  logic             rewind,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic             err
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1'b1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             err_q;
  logic             err_d;
  logic [PTR_W-1:0] rd_ptr_s;
  logic             full_s;
  logic             empty_s;
  logic             wr_ok_s;

  assign full_s  = (count_q == DEPTH_CNT);
  assign empty_s = (count_q == '0);
  // clear has priority, so an append in the same cycle is discarded.
  assign wr_ok_s = wr_en && !full_s && !clear;

  // Read pointer sees the pre-write count, so a key written this cycle is
  // not reachable until the following cycle.
  key_ring_ptr #(
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .count  (count_q),
    .dir    (dir),
    .rd_en  (rd_en),
    .rewind (rewind),
    .rd_ptr (rd_ptr_s)
  );

  // Next occupancy and sticky error.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (wr_ok_s) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
      // Rewind outranks rd_en, so a rewind on an empty store is not an error.
      if ((wr_en && full_s) || (rd_en && !rewind && empty_s)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // Occupancy and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Key memory; reset wipes every entry so no key material survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_q[count_q[PTR_W-1:0]] <= din;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign dout       = mem_q[rd_ptr_s];
  assign dout_valid = !empty_s;
  assign count      = count_q;
  assign full       = full_s;
  assign empty      = empty_s;
  assign err        = err_q;
  assign last       = !empty_s &&
                      ((dir == DIR_REV) ? (rd_ptr_s == '0)
                                        : (rd_ptr_s == PTR_W'(count_q - CNT_ONE)));

endmodule : key_ring_store

// File: tb/tb_key_ring_store.sv
// -----------------------------------------------------------------------------
// tb_key_ring_store
// Directed bench for key_ring_store with WIDTH=8, DEPTH=4.
// -----------------------------------------------------------------------------
module tb_key_ring_store;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             dir;
  logic             rewind;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             last;
  logic             err;

  int checks = 0;
  int errors = 0;

  key_ring_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .din        (din),
    .rd_en      (rd_en),
    .dir        (dir),
    .rewind     (rewind),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .last       (last),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; inputs are sampled at the edge, outputs observed 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] d);
    wr_en = 1'b1; din = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic d);
    rd_en = 1'b1; dir = d;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_rewind(input logic d);
    rewind = 1'b1; dir = d;
    step();
    rewind = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; din = 8'h00;
    rd_en = 1'b0; dir = 1'b0; rewind = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h want %h", dout, 8'h00); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", dout_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (full !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rst_flags full=%b empty=%b want 0/1", full, empty); end
    checks++; if (last !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_last_err last=%b err=%b want 0/0", last, err); end
  endtask

  task automatic test_load();
    do_write(8'h11); do_write(8'h22); do_write(8'h33);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL load_count got %0d want 3", count); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL load_flags empty=%b full=%b want 0/0", empty, full); end
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL load_dout got %h want 11", dout); end
    checks++; if (last !== 1'b0 || dout_valid !== 1'b1) begin errors++; $display("FAIL load_last_valid last=%b valid=%b want 0/1", last, dout_valid); end
  endtask

  task automatic test_forward_wrap();
    logic [WIDTH-1:0] exp_d [4];
    logic             exp_l [4];
    exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b1;  exp_l[2] = 1'b0;  exp_l[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read(1'b0);
      checks++; if (dout !== exp_d[i] || last !== exp_l[i]) begin errors++; $display("FAIL fwd_%0d dout=%h last=%b want %h/%b", i, dout, last, exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_reverse();
    logic [WIDTH-1:0] exp_d [3];
    logic             exp_l [3];
    exp_d[0] = 8'h22; exp_d[1] = 8'h11; exp_d[2] = 8'h33;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b1;  exp_l[2] = 1'b0;
    do_rewind(1'b1);
    checks++; if (dout !== 8'h33 || last !== 1'b0) begin errors++; $display("FAIL rev_rewind dout=%h last=%b want 33/0", dout, last); end
    for (int i = 0; i < 3; i++) begin
      do_read(1'b1);
      checks++; if (dout !== exp_d[i] || last !== exp_l[i]) begin errors++; $display("FAIL rev_%0d dout=%h last=%b want %h/%b", i, dout, last, exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_overflow();
    do_write(8'h44);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL ovf_full full=%b count=%0d want 1/4", full, count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got %b want 0", err); end
    do_write(8'h55);
    checks++; if (count !== 3'd4 || err !== 1'b1) begin errors++; $display("FAIL ovf_drop count=%0d err=%b want 4/1", count, err); end
    do_rewind(1'b1);
    checks++; if (dout !== 8'h44 || last !== 1'b0) begin errors++; $display("FAIL ovf_mem3 dout=%h last=%b want 44/0", dout, last); end
    do_clear();
    checks++; if (count !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL clr_count_err count=%0d err=%b want 0/0", count, err); end
    checks++; if (empty !== 1'b1 || dout_valid !== 1'b0 || last !== 1'b0) begin errors++; $display("FAIL clr_flags empty=%b valid=%b last=%b want 1/0/0", empty, dout_valid, last); end
    // Memory survives clear; pointer back at 0 shows the old first key.
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL clr_mem_kept dout=%h want 11", dout); end
  endtask

  task automatic test_empty_read();
    do_read(1'b0);
    checks++; if (err !== 1'b1 || dout !== 8'h11) begin errors++; $display("FAIL empty_rd err=%b dout=%h want 1/11", err, dout); end
    do_rewind(1'b1);
    checks++; if (err !== 1'b1 || dout !== 8'h11) begin errors++; $display("FAIL empty_rew_keep err=%b dout=%h want 1/11", err, dout); end
    do_clear();
    do_rewind(1'b1);
    checks++; if (err !== 1'b0 || dout !== 8'h11) begin errors++; $display("FAIL empty_rew_noerr err=%b dout=%h want 0/11", err, dout); end
  endtask

  task automatic test_back_to_back();
    do_write(8'hAA); do_write(8'hBB);
    do_read(1'b0);
    checks++; if (dout !== 8'hBB || last !== 1'b1) begin errors++; $display("FAIL b2b_pre dout=%h last=%b want bb/1", dout, last); end
    wr_en = 1'b1; din = 8'hCC; rd_en = 1'b1; dir = 1'b0;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (dout !== 8'hAA || count !== 3'd3 || last !== 1'b0) begin errors++; $display("FAIL b2b_wrap dout=%h count=%0d last=%b want aa/3/0", dout, count, last); end
    do_read(1'b0); do_read(1'b0);
    checks++; if (dout !== 8'hCC || last !== 1'b1) begin errors++; $display("FAIL b2b_new dout=%h last=%b want cc/1", dout, last); end
    // clear outranks a same-cycle write.
    clear = 1'b1; wr_en = 1'b1; din = 8'hEE;
    step();
    clear = 1'b0; wr_en = 1'b0;
    checks++; if (count !== 3'd0 || dout !== 8'hAA) begin errors++; $display("FAIL clr_wr count=%0d dout=%h want 0/aa", count, dout); end
  endtask

  task automatic test_single_entry();
    do_write(8'h5A);
    do_read(1'b0);
    checks++; if (dout !== 8'h5A || last !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL single_fwd dout=%h last=%b count=%0d want 5a/1/1", dout, last, count); end
    do_read(1'b1);
    checks++; if (dout !== 8'h5A || last !== 1'b1) begin errors++; $display("FAIL single_rev dout=%h last=%b want 5a/1", dout, last); end
  endtask

  task automatic test_async_reset();
    do_write(8'h66);
    do_read(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    // Still before the next rising edge: reset must already be visible.
    checks++; if (count !== 3'd0 || dout !== 8'h00 || empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL async_rst count=%0d dout=%h empty=%b err=%b want 0/00/1/0", count, dout, empty, err); end
    step();
    rst = 1'b0;
    step();
    checks++; if (dout_valid !== 1'b0 || last !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL post_rst valid=%b last=%b full=%b want 0/0/0", dout_valid, last, full); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward_wrap();
    test_reverse();
    test_overflow();
    test_empty_read();
    test_back_to_back();
    test_single_entry();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_key_ring_store
